// File: rtl/tdpr_pkg.sv
// Shared definitions for the True_DPR block-copy engine and the RAM it drives.
package tdpr_pkg;

   localparam int ADDR_SIZE_DEF = 8;
   localparam int DATA_SIZE_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } tdpr_state_e;

endpackage

// File: rtl/tdpr_addr_gen.sv
// Loadable up/down address counter: starts at base (ascending) or base+len-1 (descending).
module tdpr_addr_gen #(
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic [ADDR_SIZE-1:0] base_i,
   input  logic [ADDR_SIZE-1:0] len_i,
   input  logic                 desc_i,
   input  logic                 step_i,
   output logic [ADDR_SIZE-1:0] addr_o
);

   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic                 desc_q, desc_d;

   // len_i is the word count modulo RAM_SIZE, so a full-memory copy wraps to base-1 as intended.
   always_comb begin
      addr_d = addr_q;
      desc_d = desc_q;
      if (load_i) begin
         desc_d = desc_i;
         addr_d = desc_i ? (base_i + len_i - 1'b1) : base_i;
      end else if (step_i) begin
         addr_d = desc_q ? (addr_q - 1'b1) : (addr_q + 1'b1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         desc_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         desc_q <= desc_d;
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/tdpr_copy_engine.sv
// Block-copy master for True_DPR: reads through port A, writes one cycle later through port B,
// choosing the copy direction so overlapping ranges behave like memmove.
module tdpr_copy_engine
   import tdpr_pkg::*;
#(
   parameter int ADDR_SIZE = ADDR_SIZE_DEF,
   parameter int DATA_SIZE = DATA_SIZE_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADDR_SIZE-1:0] src_addr,
   input  logic [ADDR_SIZE-1:0] dst_addr,
   input  logic [ADDR_SIZE:0]   len,
   output logic                 busy,
   output logic                 done,
   output logic                 en_a,
   output logic                 we_a,
   output logic [ADDR_SIZE-1:0] addr_a,
   input  logic [DATA_SIZE-1:0] dout_a,
   output logic                 en_b,
   output logic                 we_b,
   output logic [ADDR_SIZE-1:0] addr_b,
   output logic [DATA_SIZE-1:0] din_b
);

   tdpr_state_e        state_q, state_d;
   logic [ADDR_SIZE:0] cnt_q, cnt_d;
   logic               wvld_q, wvld_d;
   logic               load;
   logic               desc;

   // Copying downward whenever the destination sits above the source keeps reads ahead of writes.
   assign desc = (dst_addr > src_addr);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      wvld_d  = (state_q == READ);
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  state_d = READ;
                  cnt_d   = len;
                  load    = 1'b1;
               end else begin
                  state_d = FIN;
               end
            end
         end
         READ: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == {{ADDR_SIZE{1'b0}}, 1'b1}) state_d = DRAIN;
         end
         DRAIN:   state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wvld_q  <= wvld_d;
      end
   end

   tdpr_addr_gen #(.ADDR_SIZE(ADDR_SIZE)) u_rd_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load),
      .base_i (src_addr),
      .len_i  (len[ADDR_SIZE-1:0]),
      .desc_i (desc),
      .step_i (state_q == READ),
      .addr_o (addr_a)
   );

   tdpr_addr_gen #(.ADDR_SIZE(ADDR_SIZE)) u_wr_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load),
      .base_i (dst_addr),
      .len_i  (len[ADDR_SIZE-1:0]),
      .desc_i (desc),
      .step_i (wvld_q),
      .addr_o (addr_b)
   );

   assign busy  = (state_q == READ) || (state_q == DRAIN);
   assign done  = (state_q == FIN);
   assign en_a  = (state_q == READ);
   assign we_a  = 1'b0;
   assign en_b  = wvld_q;
   assign we_b  = wvld_q;
   // Read data flows straight to port B; the gate only keeps din_b quiet between writes.
   assign din_b = {DATA_SIZE{wvld_q}} & dout_a;

endmodule
